// File: rtl/cache_line_arbiter.sv
// Round-robin arbiter sharing one DRAM line port between the I-cache and D-cache.
// Squashed I-cache fills are drained on the memory side and never reported back.
module cache_line_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DRAIN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic                last_grant;
  logic                i_req;
  logic                d_req;
  logic                grant_d;

  assign i_req = i_read && !flush;
  assign d_req = d_read || d_write;
  // last_grant: 0 = I, 1 = D; on a tie the side not served last wins.
  assign grant_d = d_req && (!i_req || !last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_grant <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= SERVE_D;
            addr_q     <= d_addr;
            wdata_q    <= d_wdata;
            last_grant <= 1'b1;
            mem_read   <= d_read;
            mem_write  <= d_write;
          end else if (i_req) begin
            state      <= SERVE_I;
            addr_q     <= i_addr;
            last_grant <= 1'b0;
            mem_read   <= 1'b1;
            mem_write  <= 1'b0;
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            state    <= IDLE;
            mem_read <= 1'b0;
          end else if (flush) begin
            // Memory still owes us a line; keep the read up and swallow it.
            state <= DRAIN;
          end
        end
        SERVE_D, DRAIN: begin
          if (mem_resp) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign i_resp    = (state == SERVE_I) && mem_resp && !flush;
  assign d_resp    = (state == SERVE_D) && mem_resp;

endmodule
